// File: rtl/alu_issue_scheduler_if.sv
// Shared item/unit types and the enqueue/issue/writeback bundle
// between decode, the ALU issue scheduler and register read.
package exut;
  typedef enum logic [1:0] {
    EXU_ALU = 2'd0,
    EXU_MUL = 2'd1,
    EXU_DIV = 2'd2,
    EXU_MEM = 2'd3
  } exe_unit_type_t;

  typedef struct packed {
    exe_unit_type_t exu_type;
    logic [5:0]     op;
    logic           has_rs1;
    logic [4:0]     rs1;
    logic           has_rs2;
    logic [4:0]     rs2;
    logic           has_rd;
    logic [4:0]     rd;
    logic [15:0]    imm;
  } queue_item_t;
endpackage

interface alu_issue_scheduler_if;
  import exut::*;

  logic           enq_valid;
  logic           enq_ready;
  queue_item_t    enq_item;
  logic           flush;
  logic           iss_valid;
  queue_item_t    iss_item;
  exe_unit_type_t iss_unit;
  logic           alu_wb_valid;
  logic [4:0]     alu_wb_rd;
  logic           mul_wb_valid;
  logic [4:0]     mul_wb_rd;
  logic           div_wb_valid;
  logic [4:0]     div_wb_rd;

  modport slave (
    input  enq_valid, enq_item, flush,
    input  alu_wb_valid, alu_wb_rd, mul_wb_valid, mul_wb_rd, div_wb_valid, div_wb_rd,
    output enq_ready, iss_valid, iss_item, iss_unit
  );

  modport master (
    output enq_valid, enq_item, flush,
    output alu_wb_valid, alu_wb_rd, mul_wb_valid, mul_wb_rd, div_wb_valid, div_wb_rd,
    input  enq_ready, iss_valid, iss_item, iss_unit
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Out-of-order issue scheduler: age-ordered collapsing queue with a register
// scoreboard, issuing the oldest ready entry per cycle to ALU/MUL/DIV.
module alu_issue_scheduler
  import exut::*;
#(
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  alu_issue_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  queue_item_t      q_q [DEPTH];
  queue_item_t      q_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      busy_q, busy_d;
  logic             div_inflight_q, div_inflight_d;
  logic             iss_valid_q, iss_valid_d;
  queue_item_t      iss_item_q, iss_item_d;
  exe_unit_type_t   iss_unit_q, iss_unit_d;

  logic [DEPTH-1:0] ready;
  logic             sel_valid;
  logic [CNT_W-1:0] sel_idx;
  logic [CNT_W-1:0] wr_idx;
  queue_item_t      sel_item;
  logic             enq_ready;
  logic             enq_fire;

  assign enq_ready = !rst && (count_q != CNT_W'(DEPTH));
  assign enq_fire  = bus.enq_valid && enq_ready && !bus.flush;

  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = (CNT_W'(i) < count_q)
              && (!q_q[i].has_rs1 || !busy_q[q_q[i].rs1])
              && (!q_q[i].has_rs2 || !busy_q[q_q[i].rs2])
              && (!q_q[i].has_rd  || !busy_q[q_q[i].rd])
              && ((q_q[i].exu_type != EXU_DIV) || !div_inflight_q);
    end
  end

  // Descending scan so the lowest (oldest) ready index is the last one written.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_item  = q_q[0];
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i] && !bus.flush) begin
        sel_valid = 1'b1;
        sel_idx   = CNT_W'(i);
        sel_item  = q_q[i];
      end
    end
  end

  always_comb begin
    q_d = q_q;
    if (sel_valid) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CNT_W'(i) >= sel_idx) q_d[i] = q_q[i + 1];
      end
    end
    wr_idx = count_q - CNT_W'(sel_valid);
    if (enq_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) q_d[i] = bus.enq_item;
      end
    end
    if (bus.flush) count_d = '0;
    else           count_d = count_q + CNT_W'(enq_fire) - CNT_W'(sel_valid);
  end

  // Clears are applied before the set so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (bus.alu_wb_valid) busy_d[bus.alu_wb_rd] = 1'b0;
    if (bus.mul_wb_valid) busy_d[bus.mul_wb_rd] = 1'b0;
    if (bus.div_wb_valid) busy_d[bus.div_wb_rd] = 1'b0;
    if (sel_valid && sel_item.has_rd) busy_d[sel_item.rd] = 1'b1;
    busy_d[0] = 1'b0;

    div_inflight_d = div_inflight_q;
    if (bus.div_wb_valid) div_inflight_d = 1'b0;
    if (sel_valid && (sel_item.exu_type == EXU_DIV)) div_inflight_d = 1'b1;
  end

  always_comb begin
    iss_valid_d = sel_valid;
    iss_item_d  = sel_valid ? sel_item : iss_item_q;
    iss_unit_d  = sel_valid ? sel_item.exu_type : iss_unit_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      div_inflight_q <= 1'b0;
      iss_valid_q    <= 1'b0;
      iss_item_q     <= '0;
      iss_unit_q     <= EXU_ALU;
    end else begin
      q_q            <= q_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      div_inflight_q <= div_inflight_d;
      iss_valid_q    <= iss_valid_d;
      iss_item_q     <= iss_item_d;
      iss_unit_q     <= iss_unit_d;
    end
  end

  assign bus.enq_ready = enq_ready;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_item  = iss_item_q;
  assign bus.iss_unit  = iss_unit_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler: inputs change and outputs are
// sampled on the falling edge, half a cycle away from the rising edge.
module tb_alu_issue_scheduler;
  import exut::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic any_iss;

  alu_issue_scheduler_if bus ();

  alu_issue_scheduler #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic queue_item_t mk(exe_unit_type_t u, logic h1, logic [4:0] r1,
                                     logic hd, logic [4:0] d);
    queue_item_t it;
    it          = '0;
    it.exu_type = u;
    it.op       = 6'h13;
    it.has_rs1  = h1;
    it.rs1      = r1;
    it.has_rd   = hd;
    it.rd       = d;
    it.imm      = {11'd0, d};
    return it;
  endfunction

  task automatic idle();
    bus.enq_valid    = 1'b0;
    bus.flush        = 1'b0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_rd    = 5'd0;
    bus.mul_wb_valid = 1'b0;
    bus.mul_wb_rd    = 5'd0;
    bus.div_wb_valid = 1'b0;
    bus.div_wb_rd    = 5'd0;
  endtask

  task automatic enq(queue_item_t it);
    bus.enq_valid = 1'b1;
    bus.enq_item  = it;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.enq_item = '0;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.enq_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_enq_ready got %0b want 0", bus.enq_ready); end
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_iss_valid got %0b want 0", bus.iss_valid); end
    tests_run++; if (bus.iss_item !== '0) begin tests_failed++; $display("[TB] FAIL rst_iss_item got %0h want 0", bus.iss_item); end
    tests_run++; if (bus.iss_unit !== EXU_ALU) begin tests_failed++; $display("[TB] FAIL rst_iss_unit got %0d want 0", bus.iss_unit); end
    tests_run++; if (dut.count_q !== CNT_W'(0)) begin tests_failed++; $display("[TB] FAIL rst_count got %0d want 0", dut.count_q); end
    tests_run++; if (dut.busy_q !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_busy got %0h want 0", dut.busy_q); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.enq_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_rst_enq_ready got %0b want 1", bus.enq_ready); end
  endtask

  task automatic test_independent();
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd1));
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ind_early_iss got %0b want 0", bus.iss_valid); end
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd2));
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd1 || bus.iss_unit !== EXU_ALU) begin tests_failed++; $display("[TB] FAIL ind_iss0 got v=%0b rd=%0d u=%0d want v=1 rd=1 u=0", bus.iss_valid, bus.iss_item.rd, bus.iss_unit); end
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd3));
    @(negedge clk);
    bus.enq_valid = 1'b0;
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd2 || bus.iss_unit !== EXU_ALU) begin tests_failed++; $display("[TB] FAIL ind_iss1 got v=%0b rd=%0d u=%0d want v=1 rd=2 u=0", bus.iss_valid, bus.iss_item.rd, bus.iss_unit); end
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd3 || bus.iss_unit !== EXU_ALU) begin tests_failed++; $display("[TB] FAIL ind_iss2 got v=%0b rd=%0d u=%0d want v=1 rd=3 u=0", bus.iss_valid, bus.iss_item.rd, bus.iss_unit); end
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ind_drain got %0b want 0", bus.iss_valid); end
    tests_run++; if (dut.busy_q !== 32'h0000_000E) begin tests_failed++; $display("[TB] FAIL ind_busy got %0h want e", dut.busy_q); end
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd1;
    bus.mul_wb_valid = 1'b1; bus.mul_wb_rd = 5'd2;
    bus.div_wb_valid = 1'b1; bus.div_wb_rd = 5'd3;
    @(negedge clk);
    idle();
    tests_run++; if (dut.busy_q !== 32'h0) begin tests_failed++; $display("[TB] FAIL triple_wb_clear got %0h want 0", dut.busy_q); end
  endtask

  task automatic test_raw_wakeup();
    enq(mk(EXU_MUL, 1'b0, 5'd0, 1'b1, 5'd5));
    @(negedge clk);
    enq(mk(EXU_ALU, 1'b1, 5'd5, 1'b1, 5'd6));
    @(negedge clk);
    bus.enq_valid = 1'b0;
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd5 || bus.iss_unit !== EXU_MUL) begin tests_failed++; $display("[TB] FAIL raw_producer got v=%0b rd=%0d u=%0d want v=1 rd=5 u=1", bus.iss_valid, bus.iss_item.rd, bus.iss_unit); end
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL raw_hold0 got %0b want 0", bus.iss_valid); end
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL raw_hold1 got %0b want 0", bus.iss_valid); end
    bus.mul_wb_valid = 1'b1; bus.mul_wb_rd = 5'd5;
    @(negedge clk);
    idle();
    tests_run++; if (bus.iss_valid !== 1'b0 || dut.busy_q[5] !== 1'b0) begin tests_failed++; $display("[TB] FAIL raw_no_bypass got v=%0b busy5=%0b want v=0 busy5=0", bus.iss_valid, dut.busy_q[5]); end
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd6 || bus.iss_unit !== EXU_ALU) begin tests_failed++; $display("[TB] FAIL raw_consumer got v=%0b rd=%0d u=%0d want v=1 rd=6 u=0", bus.iss_valid, bus.iss_item.rd, bus.iss_unit); end
    tests_run++; if (dut.busy_q !== 32'h0000_0040) begin tests_failed++; $display("[TB] FAIL raw_busy got %0h want 40", dut.busy_q); end
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd6;
    @(negedge clk);
    idle();
    tests_run++; if (dut.busy_q !== 32'h0) begin tests_failed++; $display("[TB] FAIL raw_cleanup got %0h want 0", dut.busy_q); end
  endtask

  task automatic test_ooo_bypass();
    enq(mk(EXU_DIV, 1'b0, 5'd0, 1'b1, 5'd10));
    @(negedge clk);
    enq(mk(EXU_DIV, 1'b0, 5'd0, 1'b1, 5'd7));
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd10 || bus.iss_unit !== EXU_DIV) begin tests_failed++; $display("[TB] FAIL ooo_div0 got v=%0b rd=%0d u=%0d want v=1 rd=10 u=2", bus.iss_valid, bus.iss_item.rd, bus.iss_unit); end
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd8));
    @(negedge clk);
    bus.enq_valid = 1'b0;
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ooo_div_blocked got %0b want 0", bus.iss_valid); end
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd8 || bus.iss_unit !== EXU_ALU) begin tests_failed++; $display("[TB] FAIL ooo_add_first got v=%0b rd=%0d u=%0d want v=1 rd=8 u=0", bus.iss_valid, bus.iss_item.rd, bus.iss_unit); end
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ooo_still_blocked got %0b want 0", bus.iss_valid); end
    bus.div_wb_valid = 1'b1; bus.div_wb_rd = 5'd10;
    @(negedge clk);
    idle();
    tests_run++; if (bus.iss_valid !== 1'b0 || dut.div_inflight_q !== 1'b0) begin tests_failed++; $display("[TB] FAIL ooo_div_free got v=%0b inflight=%0b want v=0 inflight=0", bus.iss_valid, dut.div_inflight_q); end
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd7 || bus.iss_unit !== EXU_DIV) begin tests_failed++; $display("[TB] FAIL ooo_div1 got v=%0b rd=%0d u=%0d want v=1 rd=7 u=2", bus.iss_valid, bus.iss_item.rd, bus.iss_unit); end
    bus.div_wb_valid = 1'b1; bus.div_wb_rd = 5'd7;
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd8;
    @(negedge clk);
    idle();
    tests_run++; if (dut.busy_q !== 32'h0 || dut.div_inflight_q !== 1'b0) begin tests_failed++; $display("[TB] FAIL ooo_cleanup got busy=%0h inflight=%0b want 0 0", dut.busy_q, dut.div_inflight_q); end
  endtask

  task automatic test_simultaneous();
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd4));
    @(negedge clk);
    bus.enq_valid = 1'b0;
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd4;
    @(negedge clk);
    idle();
    tests_run++; if (dut.busy_q[4] !== 1'b1 || bus.iss_item.rd !== 5'd4) begin tests_failed++; $display("[TB] FAIL set_wins got busy4=%0b rd=%0d want 1 4", dut.busy_q[4], bus.iss_item.rd); end
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd0));
    @(negedge clk);
    bus.enq_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd0) begin tests_failed++; $display("[TB] FAIL rd0_issue got v=%0b rd=%0d want 1 0", bus.iss_valid, bus.iss_item.rd); end
    tests_run++; if (dut.busy_q !== 32'h0000_0010) begin tests_failed++; $display("[TB] FAIL rd0_busy got %0h want 10", dut.busy_q); end
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd4;
    @(negedge clk);
    idle();
    tests_run++; if (dut.busy_q !== 32'h0) begin tests_failed++; $display("[TB] FAIL sim_cleanup got %0h want 0", dut.busy_q); end
  endtask

  task automatic test_full_flush();
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd9));
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      enq(mk(EXU_ALU, 1'b1, 5'd9, 1'b0, 5'(i + 11)));
      @(negedge clk);
    end
    bus.enq_valid = 1'b0;
    tests_run++; if (bus.enq_ready !== 1'b0 || dut.count_q !== CNT_W'(DEPTH)) begin tests_failed++; $display("[TB] FAIL full got ready=%0b count=%0d want 0 %0d", bus.enq_ready, dut.count_q, DEPTH); end
    bus.flush = 1'b1;
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd20));
    @(negedge clk);
    idle();
    tests_run++; if (dut.count_q !== CNT_W'(0) || bus.enq_ready !== 1'b1 || bus.iss_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_full got count=%0d ready=%0b v=%0b want 0 1 0", dut.count_q, bus.enq_ready, bus.iss_valid); end
    enq(mk(EXU_ALU, 1'b1, 5'd9, 1'b0, 5'd0));
    @(negedge clk);
    tests_run++; if (dut.count_q !== CNT_W'(1)) begin tests_failed++; $display("[TB] FAIL refill got count=%0d want 1", dut.count_q); end
    bus.flush = 1'b1;
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd21));
    @(negedge clk);
    idle();
    tests_run++; if (dut.count_q !== CNT_W'(0) || bus.iss_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_drop got count=%0d v=%0b want 0 0", dut.count_q, bus.iss_valid); end
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd9;
    any_iss = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      if (bus.iss_valid !== 1'b0) any_iss = 1'b1;
    end
    tests_run++; if (any_iss !== 1'b0 || dut.busy_q !== 32'h0) begin tests_failed++; $display("[TB] FAIL flush_stale_issue got iss=%0b busy=%0h want 0 0", any_iss, dut.busy_q); end
  endtask

  task automatic test_reset_mid();
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd12));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      enq(mk(EXU_ALU, 1'b1, 5'd12, 1'b0, 5'd0));
      @(negedge clk);
    end
    enq(mk(EXU_ALU, 1'b0, 5'd0, 1'b1, 5'd13));
    @(negedge clk);
    bus.enq_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_item.rd !== 5'd13 || dut.count_q !== CNT_W'(4)) begin tests_failed++; $display("[TB] FAIL mid_setup got v=%0b rd=%0d count=%0d want 1 13 4", bus.iss_valid, bus.iss_item.rd, dut.count_q); end
    rst = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.iss_valid !== 1'b0 || bus.iss_item !== '0 || bus.iss_unit !== EXU_ALU) begin tests_failed++; $display("[TB] FAIL mid_rst_iss got v=%0b item=%0h u=%0d want 0 0 0", bus.iss_valid, bus.iss_item, bus.iss_unit); end
    tests_run++; if (dut.count_q !== CNT_W'(0) || dut.busy_q !== 32'h0 || dut.div_inflight_q !== 1'b0 || bus.enq_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_state got count=%0d busy=%0h inflight=%0b ready=%0b want 0 0 0 0", dut.count_q, dut.busy_q, dut.div_inflight_q, bus.enq_ready); end
    rst = 1'b0;
    idle();
    any_iss = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.iss_valid !== 1'b0) any_iss = 1'b1;
    end
    tests_run++; if (any_iss !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_stale got %0b want 0", any_iss); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_independent();
    test_raw_wakeup();
    test_ooo_bypass();
    test_simultaneous();
    test_full_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
